// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Pattern sequencer for an 8-LED bank. Holds an IDLE/RUN/PAUSE
//               state, divides clk into a step tick and advances one of four
//               animations (binary count, rotate, bounce, blink) per tick.
// Ports       : clk      - system clock, rising edge
//               rstn     - asynchronous active-low reset
//               start    - start from IDLE or resume from PAUSE (level)
//               stop     - pause from RUN, or return to IDLE from PAUSE;
//                          wins over start
//               mode     - animation select (latched on IDLE->RUN)
//               pattern  - user pattern for blink mode (latched on IDLE->RUN)
//               leds     - registered LED drive, bit 0 = D2 .. bit 7 = D9
//               busy     - high in RUN or PAUSE
//               step     - one-cycle pulse with each tick-driven leds update
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter int DIV = 3_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [7:0] pattern,
    output logic [7:0] leds,
    output logic       busy,
    output logic       step
);

    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    localparam logic [1:0] c_MODE_COUNT  = 2'b00;
    localparam logic [1:0] c_MODE_ROTATE = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b10;

    // r_dir encoding: 0 = shifting left, 1 = shifting right
    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [7:0]      r_leds,    w_leds_nxt;
    logic            r_step,    w_step_nxt;
    logic [c_CW-1:0] r_cnt,     w_cnt_nxt;
    logic            r_dir,     w_dir_nxt;
    logic [1:0]      r_mode,    w_mode_nxt;
    logic [7:0]      r_pattern, w_pattern_nxt;

    // First frame shown when a run is launched from IDLE.
    function automatic logic [7:0] f_init(input logic [1:0] m, input logic [7:0] p);
        case (m)
            c_MODE_COUNT:  f_init = 8'h00;
            c_MODE_ROTATE: f_init = 8'h01;
            c_MODE_BOUNCE: f_init = 8'h01;
            default:       f_init = p;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_leds    <= 8'h00;
            r_step    <= 1'b0;
            r_cnt     <= '0;
            r_dir     <= c_DIR_LEFT;
            r_mode    <= 2'b00;
            r_pattern <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_leds    <= w_leds_nxt;
            r_step    <= w_step_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
            r_mode    <= w_mode_nxt;
            r_pattern <= w_pattern_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_leds_nxt    = r_leds;
        w_step_nxt    = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_dir_nxt     = r_dir;
        w_mode_nxt    = r_mode;
        w_pattern_nxt = r_pattern;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt   = S_RUN;
                    w_mode_nxt    = mode;
                    w_pattern_nxt = pattern;
                    w_cnt_nxt     = '0;
                    w_dir_nxt     = c_DIR_LEFT;
                    w_leds_nxt    = f_init(mode, pattern);
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Freeze everything; a stop on a tick edge leaves the
                    // prescaler at its last value so the tick fires on resume.
                    w_state_nxt = S_PAUSE;
                end else if (r_cnt == c_LAST) begin
                    w_cnt_nxt  = '0;
                    w_step_nxt = 1'b1;
                    case (r_mode)
                        c_MODE_COUNT:  w_leds_nxt = r_leds + 8'h01;
                        c_MODE_ROTATE: w_leds_nxt = {r_leds[6:0], r_leds[7]};
                        c_MODE_BOUNCE: begin
                            // Direction flips on arriving at an end so each
                            // end value is shown only once per pass.
                            if (r_dir == c_DIR_LEFT) begin
                                w_leds_nxt = {r_leds[6:0], 1'b0};
                                if (w_leds_nxt == 8'h80) w_dir_nxt = c_DIR_RIGHT;
                            end else begin
                                w_leds_nxt = {1'b0, r_leds[7:1]};
                                if (w_leds_nxt == 8'h01) w_dir_nxt = c_DIR_LEFT;
                            end
                        end
                        default:       w_leds_nxt = ~r_leds;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_leds_nxt  = 8'h00;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_leds_nxt  = 8'h00;
            end
        endcase
    end

    assign leds = r_leds;
    assign step = r_step;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl (DIV = 4). A reference
//               model tracks run time in clock cycles and derives each frame
//               arithmetically from the number of completed ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] pattern;
    logic [7:0] leds;
    logic       busy;
    logic       step;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 pause
    int         m_state;
    int         m_runcnt;   // RUN cycles accumulated since the last start
    logic [1:0] m_mode;
    logic [7:0] m_pat;
    logic [7:0] m_leds;
    logic       m_step;

    int stepcnt;

    always #5 clk = ~clk;

    led_seq_ctrl #(.DIV(DIV)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .pattern (pattern),
        .leds    (leds),
        .busy    (busy),
        .step    (step)
    );

    // Frame after n ticks of the latched animation.
    function automatic logic [7:0] frame(input int n);
        int p;
        int idx;
        case (m_mode)
            2'b00:   frame = 8'(n % 256);
            2'b01:   frame = 8'(1 << (n % 8));
            2'b10: begin
                p     = n % 14;
                idx   = (p <= 7) ? p : 14 - p;
                frame = 8'(1 << idx);
            end
            default: frame = (n % 2 == 0) ? m_pat : ~m_pat;
        endcase
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_runcnt = 0;
        m_mode   = 2'b00;
        m_pat    = 8'h00;
        m_leds   = 8'h00;
        m_step   = 1'b0;
    endtask

    task automatic model_edge();
        m_step = 1'b0;
        case (m_state)
            0: if (start && !stop) begin
                m_state  = 1;
                m_mode   = mode;
                m_pat    = pattern;
                m_runcnt = 0;
                m_leds   = frame(0);
            end
            1: if (stop) begin
                m_state = 2;
            end else begin
                m_runcnt++;
                if (m_runcnt % DIV == 0) begin
                    m_leds = frame(m_runcnt / DIV);
                    m_step = 1'b1;
                end
            end
            default: if (stop) begin
                m_state = 0;
                m_leds  = 8'h00;
            end else if (start) begin
                m_state = 1;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("leds", 32'(leds), 32'(m_leds));
        check("busy", 32'(busy), 32'(m_state != 0));
        check("step", 32'(step), 32'(m_step));
    endtask

    task automatic stop_twice();
        stop = 1'b1;
        cycle();
        cycle();
        stop = 1'b0;
        check("stopped_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'b00;
        pattern = 8'h00;
        model_reset();

        // Reset held across edges
        repeat (2) @(negedge clk);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        rstn = 1'b1;
        cycle();

        // Mode 01 rotate with explicit timing points
        mode  = 2'b01;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("rot_init", 32'(leds), 32'h01);
        for (int k = 1; k <= 32; k++) begin
            cycle();
            if (k == 3)  check("rot_no_early_step", 32'(step), 32'd0);
            if (k == 4)  check("rot_first", 32'({leds, 7'd0, step}), 32'({8'h02, 8'h01}));
            if (k == 5)  check("rot_step_width", 32'(step), 32'd0);
            if (k == 28) check("rot_80", 32'(leds), 32'h80);
            if (k == 32) check("rot_wrap", 32'(leds), 32'h01);
        end
        stop_twice();

        // Mode 00 full count with wrap
        mode  = 2'b00;
        start = 1'b1;
        cycle();
        start   = 1'b0;
        stepcnt = 0;
        repeat (256 * DIV) begin
            cycle();
            stepcnt += int'(step);
        end
        check("cnt_steps", 32'(stepcnt), 32'd256);
        check("cnt_wrap", 32'(leds), 32'h00);
        stop_twice();

        // Mode 10 bounce
        mode  = 2'b10;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (16 * DIV) cycle();
        check("bounce_16", 32'(leds), 32'h04);
        stop_twice();

        // Mode 11 blink with pause/resume
        mode    = 2'b11;
        pattern = 8'hA5;
        start   = 1'b1;
        cycle();
        start = 1'b0;
        check("blink_init", 32'(leds), 32'hA5);
        repeat (DIV) cycle();
        check("blink_first", 32'(leds), 32'h5A);
        repeat (2) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (6) cycle();
        check("pause_hold", 32'({leds, 7'd0, busy}), 32'({8'h5A, 8'h01}));
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("resume_wait", 32'(leds), 32'h5A);
        cycle();
        check("resume_tick", 32'({leds, 7'd0, step}), 32'({8'hA5, 8'h01}));
        stop_twice();
        check("stopped_leds", 32'(leds), 32'h00);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        check("both_idle", 32'(busy), 32'd0);

        // Mode change in RUN ignored; stop on a tick edge
        stop  = 1'b0;
        mode  = 2'b01;
        start = 1'b1;
        cycle();
        start = 1'b0;
        mode  = 2'b00;
        repeat (7) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_on_tick", 32'({leds, 7'd0, step}), 32'({8'h02, 8'h00}));
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("tick_after_resume", 32'({leds, 7'd0, step}), 32'({8'h04, 8'h01}));
        repeat (DIV) cycle();
        check("pre_reset", 32'(leds), 32'h08);

        // Asynchronous reset between edges
        #2 rstn = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'h00);
        check("async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) cycle();
        check("post_reset", 32'(leds), 32'h00);

        // Randomized control traffic
        repeat (600) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 24) == 0);
            mode    = 2'($urandom_range(0, 3));
            pattern = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer for the 8-LED bank on the iCE40-HX8K board (D2..D9). It holds the run/pause/idle state, divides the system clock into a step tick, and produces the next LED pattern on each tick. It supports four selectable animations. It sits between the user-control logic (buttons or a host register) and the LED pins, and is the only driver of the LED bank.

## Interface
- DIV, 3_000_000: system-clock cycles per pattern step (4 Hz at 12 MHz); legal range ≥1; counter width is $clog2(DIV), minimum 1
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  level sampled each clk edge; start or resume the sequence
- stop  in  1  level sampled each clk edge; pause, or return to idle if already paused
- mode  in  2  animation select: 00 binary count, 01 rotate, 10 bounce, 11 blink
- pattern  in  8  user pattern for mode 11
- leds  out  8  LED drive, bit 0 = D2 ... bit 7 = D9, registered
- busy  out  1  high in RUN or PAUSE
- step  out  1  one-cycle pulse, registered, coincident with each leds update from a tick

## Operation
- Single clock domain. rstn asynchronously forces these values:
  - state IDLE
  - leds 8'h00, busy 0, step 0
  - prescaler 0
  - dir left
  - latched mode 00
  - latched pattern 8'h00
- States are IDLE, RUN and PAUSE. Transitions are evaluated at each clk edge; stop has priority when start and stop are both high.
  - IDLE + start (stop low) -> RUN. In the same edge: latch mode and pattern, clear the prescaler, set dir left, load the initial leds value.
  - RUN + stop -> PAUSE. leds and prescaler freeze; no step pulses.
  - PAUSE + start (stop low) -> RUN. Resume from the frozen leds and prescaler with no reload.
  - PAUSE + stop -> IDLE. leds cleared to 8'h00.
  - Any other input combination: stay in the current state.
- Mode and pattern are latched only on the IDLE->RUN transition. Changes to them in RUN or PAUSE are ignored until the next start from IDLE.
- Initial leds value and per-tick update for each mode:
  - 00: initial 8'h00; leds+1 modulo 256, so 8'hFF wraps to 8'h00.
  - 01: initial 8'h01; rotate left by 1, so 8'h80 goes to 8'h01.
  - 10: initial 8'h01, dir left.
    - While dir is left, shift left; on reaching 8'h80, dir becomes right.
    - While dir is right, shift right; on reaching 8'h01, dir becomes left.
    - The sequence is 01,02,...,80,40,...,01,02,...; period 14 ticks, with no repeated end values.
  - 11: initial = latched pattern; each tick leds <= ~leds (blink).
- busy is decoded from the registered state: 1 in RUN or PAUSE, 0 in IDLE.

## Timing
- Prescaler behaviour:
  - Counts only in RUN.
  - A tick occurs in a RUN cycle when prescaler == DIV-1; the prescaler then wraps to 0.
  - With DIV=1, every RUN cycle is a tick.
- Start latency. If start is sampled at edge N in IDLE:
  - leds holds the initial value and busy=1 after edge N.
  - The first update occurs at edge N+DIV.
  - Further updates occur every DIV edges while in RUN.
- step is high for exactly the one cycle following each tick edge, and 0 otherwise, including on IDLE->RUN loads.
- stop sampled on a tick edge while in RUN: stop wins and no update occurs; the prescaler holds at DIV-1.
- After a resume, the first update follows after the remaining prescaler count, so pause time is excluded from the step period.
- rstn asserted mid-RUN clears leds immediately (asynchronously). After rstn is released, the block sits in IDLE until a start.

## Test plan
- All scenarios use DIV=4.
- Reset and start, mode 01:
  - Hold rstn=0 -> leds=00, busy=0, step=0.
  - Release, pulse start at edge N -> leds=01 after N. At N+4 leds=02 and step=1 for one cycle. At N+28 leds=80; at N+32 leds=01 (wrap).
- Mode 00 wrap: start, run 256 ticks -> leds goes 00,01,...,FF,00. step count = 256; no extra pulses.
- Mode 10 bounce: start, run 16 ticks -> leds 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04; 80 and 01 never appear twice consecutively.
- Pause/resume/stop, mode 11, pattern=A5:
  - start -> A5; after 4 cycles -> 5A.
  - stop 2 cycles after a tick -> leds holds 5A, busy=1, no step.
  - start -> next update 2 cycles later to A5.
  - stop twice -> leds=00, busy=0.
- Simultaneous and ignored inputs:
  - start=stop=1 in IDLE -> stays IDLE.
  - In RUN, change mode to 00 -> animation unchanged.
  - stop on a tick edge -> no leds change, no step.
- Async reset mid-run: assert rstn=0 between clk edges during RUN with leds=08 -> leds=00 and busy=0 before the next clk edge. Release -> IDLE, leds stays 00.
